// File: rtl/locking_pkg.sv
// Shared definitions for the logic-locking key path: key-loader FSM states and
// the default key width used by the loader and the locked-circuit wrappers.
package locking_pkg;

  localparam int KEY_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } key_loader_state_t;

endpackage

// File: rtl/key_shift_reg.sv
// Shadow key register, received-bit counter and running even-parity accumulator
// for one serial key frame.
module key_shift_reg
  import locking_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT,
  parameter int CNT_W     = $clog2(KEY_WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 shift,
  input  logic                 bit_in,
  output logic [KEY_WIDTH-1:0] shadow,
  output logic [CNT_W-1:0]     cnt,
  output logic                 parity
);

  // The parity bit arrives when cnt has reached KEY_WIDTH; it only feeds the
  // parity accumulator and never enters the shadow register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (start) begin
      shadow <= {{(KEY_WIDTH-1){1'b0}}, bit_in};
      cnt    <= CNT_W'(1);
      parity <= bit_in;
    end else if (shift) begin
      if (cnt < CNT_W'(KEY_WIDTH))
        shadow <= {shadow[KEY_WIDTH-2:0], bit_in};
      cnt    <= cnt + CNT_W'(1);
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/key_loader.sv
// Serial key-delivery front end: receives a parity-protected key frame over a
// valid/ready stream and commits it to the held key register of a locked circuit.
module key_loader
  import locking_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT,
  parameter int CNT_W     = $clog2(KEY_WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  input  logic                 abort,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 load_done,
  output logic                 load_error,
  output logic                 busy
);

  key_loader_state_t      state;
  logic [KEY_WIDTH-1:0]   shadow;
  logic [CNT_W-1:0]       cnt;
  logic                   parity;
  logic                   accept;
  logic                   sr_clear;
  logic                   sr_start;
  logic                   sr_shift;

  // Ready is decoded from state only; it is held low while reset is applied.
  assign bit_ready = !rst && ((state == IDLE) || (state == SHIFT));
  assign busy      = (state != IDLE);
  assign accept    = bit_valid && bit_ready;

  always_comb begin
    sr_clear = 1'b0;
    sr_start = 1'b0;
    sr_shift = 1'b0;
    case (state)
      IDLE:    sr_start = accept;
      SHIFT: begin
        sr_clear = abort;
        sr_shift = accept && !abort;
      end
      CHECK:   sr_clear = abort || parity;
      COMMIT:  sr_clear = 1'b1;
      default: sr_clear = 1'b1;
    endcase
  end

  key_shift_reg #(
    .KEY_WIDTH (KEY_WIDTH),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clear  (sr_clear),
    .start  (sr_start),
    .shift  (sr_shift),
    .bit_in (bit_in),
    .shadow (shadow),
    .cnt    (cnt),
    .parity (parity)
  );

  // An abort during CHECK wins over the parity verdict, so a half-checked
  // frame can never disturb the committed key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key        <= '0;
      key_valid  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            load_error <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort)
            state <= IDLE;
          else if (accept && (cnt == CNT_W'(KEY_WIDTH)))
            state <= CHECK;
        end
        CHECK: begin
          if (abort) begin
            state <= IDLE;
          end else if (!parity) begin
            state <= COMMIT;
          end else begin
            key        <= '0;
            key_valid  <= 1'b0;
            load_error <= 1'b1;
            state      <= IDLE;
          end
        end
        COMMIT: begin
          key       <= shadow;
          key_valid <= 1'b1;
          load_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed self-checking bench for key_loader with KEY_WIDTH = 8.
module tb_key_loader;

  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_in;
  logic          bit_valid;
  logic          abort;
  logic          bit_ready;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          load_done;
  logic          load_error;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  key_loader #(.KEY_WIDTH(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .abort      (abort),
    .key        (key),
    .key_valid  (key_valid),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs, then advance one clock and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic v, input logic b, input logic ab);
    bit_valid = v;
    bit_in    = b;
    abort     = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic sendKey(input logic [KW-1:0] k, input bit bubbles);
    for (int i = KW - 1; i >= 0; i--) begin
      if (bubbles)
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(1'b1, k[i], 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_key",        32'(key),        32'h0);
    checkOutput("rst_key_valid",  32'(key_valid),  32'h0);
    checkOutput("rst_load_done",  32'(load_done),  32'h0);
    checkOutput("rst_load_error", 32'(load_error), 32'h0);
    checkOutput("rst_busy",       32'(busy),       32'h0);
    checkOutput("rst_bit_ready",  32'(bit_ready),  32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(bit_ready), 32'h1);

    // Good frame 0x6D, parity 1; commit visible three cycles after parity edge
    sendKey(8'h6D, 1'b0);
    checkOutput("good_busy_mid", 32'(busy),      32'h1);
    checkOutput("good_kv_mid",   32'(key_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("good_t1_ready", 32'(bit_ready), 32'h0);
    checkOutput("good_t1_busy",  32'(busy),      32'h1);
    checkOutput("good_t1_done",  32'(load_done), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("good_t2_ready", 32'(bit_ready), 32'h0);
    checkOutput("good_t2_key",   32'(key),       32'h0);
    checkOutput("good_t2_done",  32'(load_done), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("good_t3_key",   32'(key),       32'h6D);
    checkOutput("good_t3_kv",    32'(key_valid), 32'h1);
    checkOutput("good_t3_done",  32'(load_done), 32'h1);
    checkOutput("good_t3_busy",  32'(busy),      32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("good_t4_done",  32'(load_done), 32'h0);

    // Reload 0xA5 (four ones, parity 0); old key held until the commit
    sendKey(8'hA5, 1'b0);
    checkOutput("reload_key_mid", 32'(key),       32'h6D);
    checkOutput("reload_kv_mid",  32'(key_valid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reload_t2_key",  32'(key),        32'h6D);
    checkOutput("reload_t2_err",  32'(load_error), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reload_t3_key",  32'(key),        32'hA5);
    checkOutput("reload_t3_done", 32'(load_done),  32'h1);
    checkOutput("reload_t3_err",  32'(load_error), 32'h0);

    // Abort after four bits, with a valid bit in the same cycle
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("abort_busy",  32'(busy),      32'h0);
    checkOutput("abort_key",   32'(key),       32'hA5);
    checkOutput("abort_kv",    32'(key_valid), 32'h1);
    checkOutput("abort_ready", 32'(bit_ready), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_idle",  32'(busy),      32'h0);
    sendKey(8'h6D, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("after_abort_key",  32'(key),       32'h6D);
    checkOutput("after_abort_done", 32'(load_done), 32'h1);

    // Bad parity: same key bits with parity 0
    sendKey(8'h6D, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bad_t1_key",  32'(key),        32'h6D);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bad_t2_key",  32'(key),        32'h0);
    checkOutput("bad_t2_kv",   32'(key_valid),  32'h0);
    checkOutput("bad_t2_err",  32'(load_error), 32'h1);
    checkOutput("bad_t2_done", 32'(load_done),  32'h0);
    checkOutput("bad_t2_busy", 32'(busy),       32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bad_t3_done", 32'(load_done),  32'h0);
    checkOutput("bad_t3_err",  32'(load_error), 32'h1);

    // Bubbles and backpressure: valid held high through CHECK and COMMIT
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bub_err_clear", 32'(load_error), 32'h0);
    for (int i = KW - 2; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      applyStimulus(1'b1, 1'((8'hA5 >> i) & 1), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bub_check_ready",  32'(bit_ready), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bub_commit_ready", 32'(bit_ready), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bub_key",  32'(key),       32'hA5);
    checkOutput("bub_done", 32'(load_done), 32'h1);
    checkOutput("bub_busy", 32'(busy),      32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bub_no_consume", 32'(busy), 32'h0);

    // Reset after five bits of a frame
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mrst_key",   32'(key),        32'h0);
    checkOutput("mrst_kv",    32'(key_valid),  32'h0);
    checkOutput("mrst_done",  32'(load_done),  32'h0);
    checkOutput("mrst_err",   32'(load_error), 32'h0);
    checkOutput("mrst_busy",  32'(busy),       32'h0);
    checkOutput("mrst_ready", 32'(bit_ready),  32'h0);
    rst       = 1'b0;
    bit_valid = 1'b0;
    #1;
    checkOutput("mrst_ready_after", 32'(bit_ready), 32'h1);
    sendKey(8'h6D, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mrst_reload_key", 32'(key),       32'h6D);
    checkOutput("mrst_reload_kv",  32'(key_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
